vga_sync_gen: RTL and testbench

Timing generator for the 640x480 VGA text path: divides the 100 MHz system clock to a 25 MHz pixel tick, runs horizontal and vertical pixel counters, and drives hsync, vsync, video_on and the pixel_x/pixel_y coordinates. The character renderer (`caracter`) consumes these, and the monitor connector gets hsync/vsync. All outputs are registered and mutually aligned, so the renderer sees glitch-free coordinates.

---
 rtl/vga_sync_gen.sv | 113 +++++++++++
 tb/tb_vga_sync_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 VGA timing generator.
// Divides the system clock into a pixel tick, runs the horizontal and vertical
// pixel counters, and drives registered, mutually aligned hsync/vsync/video_on
// and pixel coordinates for the character renderer and the monitor connector.
// Optional feature macro: VGA_SYNC_FRAME_START_EN enables the frame_start
// pulse; without it frame_start is tied low.
// Timing parameter sums must stay within 10 bits (total of at most 1023).
module vga_sync_gen #(
    parameter int TICK_DIV  = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP       = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP       = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] ONE10        = 10'd1;

    // TICK_DIV >= 2, so the divider is always at least one bit wide.
    localparam int                DIV_W   = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [DIV_W-1:0] div;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    // Pixel tick divider: p_tick is high for the clock after div reaches its top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= '0;
            p_tick <= 1'b0;
        end else begin
            p_tick <= (div == DIV_MAX);
            div    <= (div == DIV_MAX) ? '0 : div + DIV_ONE;
        end
    end

    // Next position: x advances on each tick, y advances when x wraps.
    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (p_tick) begin
            if (pixel_x == H_MAX) begin
                x_next = '0;
                if (pixel_y == V_MAX) begin
                    y_next = '0;
                end else begin
                    y_next = pixel_y + ONE10;
                end
            end else begin
                x_next = pixel_x + ONE10;
            end
        end
    end

    // Counters and decodes share one enable so every output moves on the same
    // edge; decoding the next position keeps the decodes aligned with it.
    // Holding video_on until the first tick blanks pixel (0,0) once after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_x  <= '0;
            pixel_y  <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else if (p_tick) begin
            pixel_x  <= x_next;
            pixel_y  <= y_next;
            hsync    <= !((x_next >= H_SYNC_FIRST) && (x_next <= H_SYNC_LAST));
            vsync    <= !((y_next >= V_SYNC_FIRST) && (y_next <= V_SYNC_LAST));
            video_on <= (x_next < H_DISP) && (y_next < V_DISP);
        end
    end

`ifdef VGA_SYNC_FRAME_START_EN
    // Frame start pulse on the edge where the position wraps to (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= p_tick && (pixel_x == H_MAX) && (pixel_y == V_MAX);
        end
    end
`else
    assign frame_start = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed testbench for vga_sync_gen. Horizontal timing uses the real 640x480
// values; vertical timing is shortened to 8 lines (4 visible, front 1, sync 2,
// back 1) so whole frames fit in a short run. vsync is then low on lines 5..6.
module tb_vga_sync_gen;

    localparam int FRAME_CLKS = 25600;   // 8 lines * 800 ticks * 4 clocks

`ifdef VGA_SYNC_FRAME_START_EN
    localparam bit FS_EN = 1'b1;
`else
    localparam bit FS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // rising edges since the last reset release

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    vga_sync_gen #(
        .TICK_DIV (4),
        .H_DISPLAY(640),
        .H_FRONT  (16),
        .H_SYNC   (96),
        .H_BACK   (48),
        .V_DISPLAY(4),
        .V_FRONT  (1),
        .V_SYNC   (2),
        .V_BACK   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_tick     (p_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start)
    );

    // One rising edge, then sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) step();
        checks++; if (pixel_x !== 10'd0) begin failures++; $display("FAIL reset_x: got %0d expected 0", pixel_x); end
        checks++; if (pixel_y !== 10'd0) begin failures++; $display("FAIL reset_y: got %0d expected 0", pixel_y); end
        checks++; if (hsync !== 1'b1) begin failures++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
        checks++; if (vsync !== 1'b1) begin failures++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
        checks++; if (video_on !== 1'b0) begin failures++; $display("FAIL reset_video_on: got %b expected 0", video_on); end
        checks++; if (p_tick !== 1'b0) begin failures++; $display("FAIL reset_p_tick: got %b expected 0", p_tick); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    endtask

    // Release reset and watch the first 12 clocks: p_tick on clocks 4, 8, 12;
    // the first position update lands on clock 5 and moves to (1,0) visible.
    task automatic test_tick();
        logic exp_tick;
        rst = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_tick = ((i % 4) == 0);
            checks++;
            if (p_tick !== exp_tick) begin
                failures++;
                $display("FAIL tick_clk%0d: got %b expected %b", i, p_tick, exp_tick);
            end
            if (i == 4) begin
                checks++;
                if (pixel_x !== 10'd0 || video_on !== 1'b0) begin
                    failures++;
                    $display("FAIL pre_update: got x=%0d von=%b expected x=0 von=0", pixel_x, video_on);
                end
            end
            if (i == 5) begin
                checks++;
                if (pixel_x !== 10'd1 || pixel_y !== 10'd0 || video_on !== 1'b1) begin
                    failures++;
                    $display("FAIL first_update: got (%0d,%0d) von=%b expected (1,0) von=1", pixel_x, pixel_y, video_on);
                end
            end
        end
    endtask

    // Run through the end of line 0. x = 656 is reached on clock 4*656+1 = 2625,
    // x = 640 on clock 2561, x = 799 on 3197..3200 and the wrap lands on 3201.
    task automatic test_line();
        int         hlow       = 0;
        int         hfirst_cyc = -1;
        int         vfall_cyc  = -1;
        logic [9:0] hfirst_x   = '0;
        logic [9:0] vfall_x    = '0;
        logic [9:0] x3200 = '0, y3200 = '0, x3201 = '0, y3201 = '0;
        logic       prev_von;
        prev_von = video_on;
        while (cyc < 3204) begin
            step();
            if (hsync === 1'b0) begin
                hlow++;
                if (hfirst_cyc < 0) begin
                    hfirst_cyc = cyc;
                    hfirst_x   = pixel_x;
                end
            end
            if (prev_von === 1'b1 && video_on === 1'b0 && vfall_cyc < 0) begin
                vfall_cyc = cyc;
                vfall_x   = pixel_x;
            end
            prev_von = video_on;
            if (cyc == 3200) begin x3200 = pixel_x; y3200 = pixel_y; end
            if (cyc == 3201) begin x3201 = pixel_x; y3201 = pixel_y; end
        end
        checks++; if (hlow != 384) begin failures++; $display("FAIL hsync_low_clocks: got %0d expected 384", hlow); end
        checks++; if (hfirst_x !== 10'd656) begin failures++; $display("FAIL hsync_start_x: got %0d expected 656", hfirst_x); end
        checks++; if (hfirst_cyc != 2625) begin failures++; $display("FAIL hsync_start_clk: got %0d expected 2625", hfirst_cyc); end
        checks++; if (vfall_x !== 10'd640) begin failures++; $display("FAIL video_off_x: got %0d expected 640", vfall_x); end
        checks++; if (vfall_cyc != 2561) begin failures++; $display("FAIL video_off_clk: got %0d expected 2561", vfall_cyc); end
        checks++;
        if (x3200 !== 10'd799 || y3200 !== 10'd0) begin
            failures++; $display("FAIL line_end_pos: got (%0d,%0d) expected (799,0)", x3200, y3200);
        end
        checks++;
        if (x3201 !== 10'd0 || y3201 !== 10'd1) begin
            failures++; $display("FAIL line_wrap_pos: got (%0d,%0d) expected (0,1)", x3201, y3201);
        end
    endtask

    // Run past the frame wrap, comparing every clock against a closed-form
    // timeline: u = (clk-1)/4 updates, x = u % 800, y = (u / 800) % 8.
    // Each signal stops being compared after its first mismatch.
    task automatic test_frame();
        int         u;
        int         vlow = 0;
        logic [9:0] ex, ey;
        logic       ehs, evs, evon, etick, efs;
        bit         bad_x = 0, bad_y = 0, bad_hs = 0, bad_vs = 0, bad_von = 0, bad_tick = 0, bad_fs = 0;
        while (cyc < FRAME_CLKS + 8) begin
            step();
            u     = (cyc - 1) / 4;
            ex    = 10'(u % 800);
            ey    = 10'((u / 800) % 8);
            ehs   = !(ex >= 10'd656 && ex <= 10'd751);
            evs   = !(ey == 10'd5 || ey == 10'd6);
            evon  = (u > 0) && (ex < 10'd640) && (ey < 10'd4);
            etick = ((cyc % 4) == 0);
            efs   = FS_EN && (cyc == FRAME_CLKS + 1);
            if (vsync === 1'b0) vlow++;
            if (!bad_x) begin checks++; if (pixel_x !== ex) begin bad_x = 1; failures++; $display("FAIL frame_x clk%0d: got %0d expected %0d", cyc, pixel_x, ex); end end
            if (!bad_y) begin checks++; if (pixel_y !== ey) begin bad_y = 1; failures++; $display("FAIL frame_y clk%0d: got %0d expected %0d", cyc, pixel_y, ey); end end
            if (!bad_hs) begin checks++; if (hsync !== ehs) begin bad_hs = 1; failures++; $display("FAIL frame_hsync clk%0d: got %b expected %b", cyc, hsync, ehs); end end
            if (!bad_vs) begin checks++; if (vsync !== evs) begin bad_vs = 1; failures++; $display("FAIL frame_vsync clk%0d: got %b expected %b", cyc, vsync, evs); end end
            if (!bad_von) begin checks++; if (video_on !== evon) begin bad_von = 1; failures++; $display("FAIL frame_video_on clk%0d: got %b expected %b", cyc, video_on, evon); end end
            if (!bad_tick) begin checks++; if (p_tick !== etick) begin bad_tick = 1; failures++; $display("FAIL frame_p_tick clk%0d: got %b expected %b", cyc, p_tick, etick); end end
            if (!bad_fs) begin checks++; if (frame_start !== efs) begin bad_fs = 1; failures++; $display("FAIL frame_start clk%0d: got %b expected %b", cyc, frame_start, efs); end end
            if (cyc == FRAME_CLKS) begin
                checks++;
                if (pixel_x !== 10'd799 || pixel_y !== 10'd7) begin
                    failures++; $display("FAIL frame_end_pos: got (%0d,%0d) expected (799,7)", pixel_x, pixel_y);
                end
            end
            if (cyc == FRAME_CLKS + 1) begin
                checks++;
                if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
                    failures++; $display("FAIL frame_wrap_pos: got (%0d,%0d) expected (0,0)", pixel_x, pixel_y);
                end
            end
        end
        // Lines 5 and 6 are fully inside this window: 2 * 3200 clocks.
        checks++; if (vlow != 6400) begin failures++; $display("FAIL vsync_low_clocks: got %0d expected 6400", vlow); end
    endtask

    // Reach (300,2) of the second frame, assert reset between edges, and confirm
    // the outputs clear before the next edge; then a fresh frame from (0,0).
    task automatic test_reset_mid();
        int fs_count = 0;
        // (300,2) in frame 2 is update 6400 + 2*800 + 300 = 8300 -> clock 33201.
        while (cyc < 33201) step();
        checks++;
        if (pixel_x !== 10'd300 || pixel_y !== 10'd2 || video_on !== 1'b1) begin
            failures++; $display("FAIL mid_pos: got (%0d,%0d) von=%b expected (300,2) von=1", pixel_x, pixel_y, video_on);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
            video_on !== 1'b0 || p_tick !== 1'b0 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fs=%b expected 0 0 1 1 0 0 0",
                     pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_start);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (cyc < FRAME_CLKS + 4) begin
            step();
            if (frame_start === 1'b1) fs_count++;
            if (cyc == 4) begin
                checks++;
                if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || p_tick !== 1'b1) begin
                    failures++; $display("FAIL restart_first_tick: got (%0d,%0d) tick=%b expected (0,0) tick=1", pixel_x, pixel_y, p_tick);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (pixel_x !== 10'd1 || pixel_y !== 10'd0) begin
                    failures++; $display("FAIL restart_pos: got (%0d,%0d) expected (1,0)", pixel_x, pixel_y);
                end
            end
            if (cyc == FRAME_CLKS) begin
                checks++;
                if (pixel_x !== 10'd799 || pixel_y !== 10'd7) begin
                    failures++; $display("FAIL restart_frame_end: got (%0d,%0d) expected (799,7)", pixel_x, pixel_y);
                end
            end
            if (cyc == FRAME_CLKS + 1) begin
                checks++;
                if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || frame_start !== FS_EN) begin
                    failures++; $display("FAIL restart_frame_wrap: got (%0d,%0d) fs=%b expected (0,0) fs=%b", pixel_x, pixel_y, frame_start, FS_EN);
                end
            end
        end
        checks++;
        if (fs_count != int'(FS_EN)) begin
            failures++; $display("FAIL restart_frame_start_count: got %0d expected %0d", fs_count, int'(FS_EN));
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_line();
        test_frame();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
